// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply, restoring divide; signed ops run on magnitudes
// and get their sign fixed up in a single FIX cycle before HI/LO are written.
module muldiv_seq #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  md_start,
  input  logic [1:0]            md_op,
  input  logic [WORD_WIDTH-1:0] md_src1,
  input  logic [WORD_WIDTH-1:0] md_src2,
  input  logic                  md_cancel,
  input  logic                  hilo_rd,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [WORD_WIDTH-1:0] hilo_wdata,
  output logic [WORD_WIDTH-1:0] hi_out,
  output logic [WORD_WIDTH-1:0] lo_out,
  output logic                  md_busy,
  output logic                  md_done,
  output logic                  md_stall
);

  localparam int W = WORD_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(WORD_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 op_div;
  logic                 neg_main;   // negate product / quotient
  logic                 neg_rem;    // negate remainder (dividend sign)
  logic [W-1:0]         opnd;       // multiplicand or divisor magnitude
  logic [W-1:0]         p_hi;       // product high / partial remainder
  logic [W-1:0]         p_lo;       // product low / dividend-then-quotient

  logic                 signed_op;
  logic                 src1_neg, src2_neg;
  logic [W-1:0]         abs1, abs2;
  logic [W:0]           mul_sum;
  logic [W:0]           div_shift, div_diff;
  logic [W-1:0]         step_hi, step_lo;
  logic [2*W-1:0]       prod_fix;
  logic [W-1:0]         fix_hi, fix_lo;

  // Operand magnitudes and one iteration of the selected algorithm
  always_comb begin
    signed_op = ~md_op[0];
    src1_neg  = signed_op & md_src1[W-1];
    src2_neg  = signed_op & md_src2[W-1];
    abs1      = src1_neg ? -md_src1 : md_src1;
    abs2      = src2_neg ? -md_src2 : md_src2;

    mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {p_hi, p_lo[W-1]};
    div_diff  = div_shift - {1'b0, opnd};

    step_hi = '0;
    step_lo = '0;
    if (op_div) begin
      // Restoring step: keep the difference only when it did not go negative
      if (!div_diff[W]) begin
        step_hi = div_diff[W-1:0];
        step_lo = {p_lo[W-2:0], 1'b1};
      end else begin
        step_hi = div_shift[W-1:0];
        step_lo = {p_lo[W-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], p_lo[W-1:1]};
    end

    prod_fix = neg_main ? -{p_hi, p_lo} : {p_hi, p_lo};
    fix_hi   = '0;
    fix_lo   = '0;
    if (op_div) begin
      fix_lo = neg_main ? -p_lo : p_lo;
      fix_hi = neg_rem  ? -p_hi : p_hi;
    end else begin
      fix_hi = prod_fix[2*W-1:W];
      fix_lo = prod_fix[W-1:0];
    end
  end

  // Sequencer FSM with HI/LO and registered busy/done flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          md_done <= 1'b0;
          // MTHI/MTLO land now even if an op starts; the op overwrites later
          if (hi_we) hi_out <= hilo_wdata;
          if (lo_we) lo_out <= hilo_wdata;
          if (md_start) begin
            state   <= CALC;
            md_busy <= 1'b1;
            cnt     <= CNT_INIT;
            op_div  <= md_op[1];
            opnd    <= md_op[1] ? abs2 : abs1;
            p_lo    <= md_op[1] ? abs1 : abs2;
            p_hi    <= '0;
            // Divide by zero keeps the raw all-ones quotient unsigned
            neg_main <= (src1_neg ^ src2_neg) & ~(md_op[1] && md_src2 == '0);
            neg_rem  <= src1_neg;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (md_cancel) begin
            state   <= IDLE;
            md_busy <= 1'b0;
          end else begin
            p_hi <= step_hi;
            p_lo <= step_lo;
            cnt  <= cnt - CNT_LAST;
            if (cnt == CNT_LAST) state <= FIX;
          end
        end
        FIX: begin
          md_busy <= 1'b0;
          if (md_cancel) begin
            state <= IDLE;
          end else begin
            hi_out  <= fix_hi;
            lo_out  <= fix_lo;
            md_done <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          state   <= IDLE;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

  assign md_stall = md_busy & (md_start | hilo_rd | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed fixups, divide boundaries,
// stall/cancel behaviour, back-to-back issue and MTHI/MTLO writes.
module tb_muldiv_seq;

  logic        clk, rst_n;
  logic        md_start, md_cancel, hilo_rd, hi_we, lo_we;
  logic [1:0]  md_op;
  logic [31:0] md_src1, md_src2, hilo_wdata;
  logic [31:0] hi_out, lo_out;
  logic        md_busy, md_done, md_stall;

  int errors = 0;
  int checks = 0;

  muldiv_seq #(.WORD_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_op(md_op),
    .md_src1(md_src1), .md_src2(md_src2), .md_cancel(md_cancel),
    .hilo_rd(hilo_rd), .hi_we(hi_we), .lo_we(lo_we), .hilo_wdata(hilo_wdata),
    .hi_out(hi_out), .lo_out(lo_out), .md_busy(md_busy), .md_done(md_done),
    .md_stall(md_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept an op on the next edge, then count edges until md_done (bounded)
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    md_op = op; md_src1 = a; md_src2 = b; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    n = 0;
    while (!md_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({hi_out, lo_out} !== 64'h0 || {md_busy, md_done, md_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy/done/stall=%b want 0", hi_out, lo_out,
               {md_busy, md_done, md_stall});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mtlo();
    hilo_wdata = 32'h1234; lo_we = 1'b1;
    @(posedge clk); #1;
    lo_we = 1'b0;
    checks++;
    if (lo_out !== 32'h1234 || hi_out !== 32'h0) begin
      errors++;
      $display("FAIL mtlo_idle: hi=%h lo=%h want 0/00001234", hi_out, lo_out);
    end
  endtask

  task automatic test_multu();
    int n;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    checks++;
    if (n !== 33) begin
      errors++;
      $display("FAIL multu_latency: edges=%0d want 33", n);
    end
    checks++;
    if (hi_out !== 32'hFFFFFFFE || lo_out !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h want fffffffe/00000001", hi_out, lo_out);
    end
    @(posedge clk); #1;
    checks++;
    if (md_done !== 1'b0 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b want 0/0", md_done, md_busy);
    end
  endtask

  task automatic test_signed();
    int n;
    do_op(2'b00, 32'hFFFFFFF9, 32'd3, n);
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL mult_neg: hi=%h lo=%h want ffffffff/ffffffeb", hi_out, lo_out);
    end
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, n);
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg: hi=%h lo=%h want ffffffff/fffffffd", hi_out, lo_out);
    end
    do_op(2'b00, 32'h00012345, 32'h00010000, n);
    checks++;
    if (hi_out !== 32'h00000001 || lo_out !== 32'h23450000) begin
      errors++;
      $display("FAIL mult_pos: hi=%h lo=%h want 00000001/23450000", hi_out, lo_out);
    end
  endtask

  task automatic test_div_boundary();
    int n;
    do_op(2'b11, 32'd100, 32'd0, n);
    checks++;
    if (hi_out !== 32'd100 || lo_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL divu_by_zero: hi=%h lo=%h want 00000064/ffffffff", hi_out, lo_out);
    end
    do_op(2'b10, 32'hFFFFFFF9, 32'd0, n);
    checks++;
    if (hi_out !== 32'hFFFFFFF9 || lo_out !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_by_zero: hi=%h lo=%h want fffffff9/ffffffff", hi_out, lo_out);
    end
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h80000000) begin
      errors++;
      $display("FAIL div_overflow: hi=%h lo=%h want 00000000/80000000", hi_out, lo_out);
    end
  endtask

  task automatic test_stall();
    int n;
    logic stall_ok;
    md_op = 2'b11; md_src1 = 32'd1000; md_src2 = 32'd7; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    hilo_rd = 1'b1;
    stall_ok = 1'b1;
    n = 0;
    while (!md_done && n < 100) begin
      #1;
      if (md_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!stall_ok || n == 100) begin
      errors++;
      $display("FAIL stall_hold: stall_ok=%b cycles=%0d want 1 until done", stall_ok, n);
    end
    checks++;
    if (md_stall !== 1'b0 || hi_out !== 32'd6 || lo_out !== 32'd142) begin
      errors++;
      $display("FAIL stall_release: stall=%b hi=%h lo=%h want 0/6/142", md_stall, hi_out, lo_out);
    end
    hilo_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cancel();
    logic saw_done;
    md_op = 2'b00; md_src1 = 32'd5; md_src2 = 32'd6; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    // MTLO while busy must be dropped
    hilo_wdata = 32'hDEAD; lo_we = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    md_cancel = 1'b1;
    @(posedge clk); #1;
    md_cancel = 1'b0; lo_we = 1'b0;
    checks++;
    if (md_busy !== 1'b0 || hi_out !== 32'd6 || lo_out !== 32'd142) begin
      errors++;
      $display("FAIL cancel_idle: busy=%b hi=%h lo=%h want 0/6/142", md_busy, hi_out, lo_out);
    end
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (md_done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0 || lo_out !== 32'd142) begin
      errors++;
      $display("FAIL cancel_no_done: saw_done=%b lo=%h want 0/142", saw_done, lo_out);
    end
  endtask

  task automatic test_mthi_with_start();
    int n;
    md_op = 2'b01; md_src1 = 32'd2; md_src2 = 32'd3; md_start = 1'b1;
    hi_we = 1'b1; hilo_wdata = 32'hABCD;
    @(posedge clk); #1;
    md_start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi_out !== 32'hABCD || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL mthi_with_start: hi=%h busy=%b want 0000abcd/1", hi_out, md_busy);
    end
    n = 0;
    while (!md_done && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'd6) begin
      errors++;
      $display("FAIL mthi_overwrite: hi=%h lo=%h want 0/6", hi_out, lo_out);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_op(2'b01, 32'd3, 32'd4, n);
    checks++;
    if (lo_out !== 32'd12 || hi_out !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first: hi=%h lo=%h want 0/12", hi_out, lo_out);
    end
    // Start already pending in DONE: second op must enter CALC directly
    md_op = 2'b11; md_src1 = 32'd50; md_src2 = 32'd7; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    checks++;
    if (md_busy !== 1'b1 || md_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_idle: busy=%b done=%b want 1/0", md_busy, md_done);
    end
    n = 0;
    while (!md_done && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n !== 33 || hi_out !== 32'd1 || lo_out !== 32'd7) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d hi=%h lo=%h want 33/1/7", n, hi_out, lo_out);
    end
  endtask

  task automatic test_reset_midop();
    md_op = 2'b01; md_src1 = 32'd9; md_src2 = 32'd9; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    hilo_rd = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hi_out, lo_out} !== 64'h0 || {md_busy, md_done, md_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_midop: hi=%h lo=%h busy/done/stall=%b want 0", hi_out, lo_out,
               {md_busy, md_done, md_stall});
    end
    hilo_rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; md_start = 1'b0; md_cancel = 1'b0; hilo_rd = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; md_op = 2'b00; md_src1 = '0; md_src2 = '0;
    hilo_wdata = '0;
    test_reset();
    test_mtlo();
    test_multu();
    test_signed();
    test_div_boundary();
    test_stall();
    test_cancel();
    test_mthi_with_start();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
